// File: rtl/uc_pkg.sv
// Shared types and opcode constants for the multicycle control unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uc_pkg;

    // Instruction sequencing states; HALT and ERR are terminal until reset.
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_HALT   = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    // Opcode class prefixes, matched on the top opcode bits in this order.
    localparam logic       PFX_ALU  = 1'b1;
    localparam logic [3:0] PFX_LDI  = 4'b0000;
    localparam logic [2:0] PFX_FLOW = 3'b001;
    localparam logic [2:0] PFX_HALT = 3'b011;

    // Flow-control sub-ops in opcode[2:0]; 101..111 fall through as NOP.
    localparam logic [2:0] FL_J    = 3'b000;
    localparam logic [2:0] FL_JZ   = 3'b001;
    localparam logic [2:0] FL_JNZ  = 3'b010;
    localparam logic [2:0] FL_CALL = 3'b011;
    localparam logic [2:0] FL_RET  = 3'b100;

    // Decoded control vector; jz/jnz mark that s_inc must be taken from z in EXEC.
    typedef struct packed {
        logic we3;
        logic wez;
        logic s_inm;
        logic s_inc;
        logic s_ret;
        logic jz;
        logic jnz;
        logic push;
        logic pop;
        logic halt;
    } ctl_t;

endpackage

// File: rtl/uc_decode.sv
// Opcode to control-vector decoder for the multicycle control unit.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output is a pure function of the opcode.
module uc_decode
    import uc_pkg::*;
#(
    parameter int OPW  = 6,
    parameter int ALUW = 3
) (
    input  logic [OPW-1:0]  opcode,
    output ctl_t            ctl,
    output logic [ALUW-1:0] op_alu
);

    // Class priority: ALU, immediate load, flow control, halt, otherwise NOP.
    always_comb begin
        ctl       = '0;
        ctl.s_inc = 1'b1;
        op_alu    = '0;
        if (opcode[OPW-1] == PFX_ALU) begin
            ctl.we3 = 1'b1;
            ctl.wez = 1'b1;
            op_alu  = opcode[ALUW-1:0];
        end else if (opcode[OPW-1:OPW-4] == PFX_LDI) begin
            ctl.s_inm = 1'b1;
            ctl.we3   = 1'b1;
        end else if (opcode[OPW-1:OPW-3] == PFX_FLOW) begin
            case (opcode[2:0])
                FL_J:    ctl.s_inc = 1'b0;
                FL_JZ:   ctl.jz    = 1'b1;
                FL_JNZ:  ctl.jnz   = 1'b1;
                FL_CALL: begin
                    ctl.push  = 1'b1;
                    ctl.s_inc = 1'b0;
                end
                FL_RET:  begin
                    ctl.pop   = 1'b1;
                    ctl.s_ret = 1'b1;
                    ctl.s_inc = 1'b0;
                end
                default: ctl.s_inc = 1'b1;
            endcase
        end else if (opcode[OPW-1:OPW-3] == PFX_HALT) begin
            ctl.halt  = 1'b1;
            ctl.s_inc = 1'b0;
        end
    end

endmodule

// File: rtl/uc_mc.sv
// Multicycle FETCH/DECODE/EXEC control unit with return-stack checks and retire counter.
// Latency: 3 cycles per instruction plus one per FETCH cycle with mem_ready low.
// Backpressure: stalls in FETCH until mem_ready; HALT/ERR hold until reset.
module uc_mc
    import uc_pkg::*;
#(
    parameter int OPW  = 6,
    parameter int ALUW = 3,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OPW-1:0]  opcode,
    input  logic            z,
    input  logic            mem_ready,
    input  logic            stack_full,
    input  logic            stack_empty,
    output logic            ir_we,
    output logic            pc_we,
    output logic            s_inc,
    output logic            s_ret,
    output logic            s_inm,
    output logic            we3,
    output logic            wez,
    output logic [ALUW-1:0] op_alu,
    output logic            push,
    output logic            pop,
    output logic            halted,
    output logic            err,
    output logic [CNTW-1:0] instr_cnt
);

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    ctl_t            dec;
    logic [ALUW-1:0] dec_alu;
    logic            stk_fault;
    logic            exec_ok;

    uc_decode #(.OPW(OPW), .ALUW(ALUW)) u_decode (
        .opcode (opcode),
        .ctl    (dec),
        .op_alu (dec_alu)
    );

    // Only the stack status relevant to the current sub-op can fault.
    assign stk_fault = (dec.push & stack_full) | (dec.pop & stack_empty);

    // EXEC retires the instruction unless it halts or faults on the stack.
    assign exec_ok = (state_q == ST_EXEC) && !dec.halt && !stk_fault;

    // Next state and retire counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                if (dec.halt) begin
                    state_d = ST_HALT;
                end else if (stk_fault) begin
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_FETCH;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            ST_HALT:   state_d = ST_HALT;
            ST_ERR:    state_d = ST_ERR;
            default:   state_d = ST_FETCH;
        endcase
    end

    // State and counter registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output gating: enables only in a retiring EXEC, all outputs forced low while reset is high.
    always_comb begin
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        s_inc     = 1'b0;
        s_ret     = 1'b0;
        s_inm     = 1'b0;
        we3       = 1'b0;
        wez       = 1'b0;
        op_alu    = '0;
        push      = 1'b0;
        pop       = 1'b0;
        halted    = 1'b0;
        err       = 1'b0;
        instr_cnt = '0;
        if (!reset) begin
            instr_cnt = cnt_q;
            ir_we     = (state_q == ST_FETCH) && mem_ready;
            halted    = (state_q == ST_HALT) || (state_q == ST_ERR);
            err       = (state_q == ST_ERR);
            if (exec_ok) begin
                pc_we  = 1'b1;
                s_inc  = dec.jz ? ~z : (dec.jnz ? z : dec.s_inc);
                s_ret  = dec.s_ret;
                s_inm  = dec.s_inm;
                we3    = dec.we3;
                wez    = dec.wez;
                op_alu = dec_alu;
                push   = dec.push;
                pop    = dec.pop;
            end
        end
    end

endmodule

// File: tb/tb_uc_mc.sv
// Bench for uc_mc: per-cycle expected output vectors queued by stimulus, checked by a monitor.
// Latency: expectations are checked on the falling edge of the cycle they were driven in.
// Backpressure: mem_ready stalls driven directly from the vector list.
module tb_uc_mc;

    localparam logic [13:0] B_IRWE = 14'h2000;
    localparam logic [13:0] B_PCWE = 14'h1000;
    localparam logic [13:0] B_SINC = 14'h0800;
    localparam logic [13:0] B_SRET = 14'h0400;
    localparam logic [13:0] B_SINM = 14'h0200;
    localparam logic [13:0] B_WE3  = 14'h0100;
    localparam logic [13:0] B_WEZ  = 14'h0080;
    localparam logic [13:0] B_A101 = 14'h0050;
    localparam logic [13:0] B_A111 = 14'h0070;
    localparam logic [13:0] B_PUSH = 14'h0008;
    localparam logic [13:0] B_POP  = 14'h0004;
    localparam logic [13:0] B_HALT = 14'h0002;
    localparam logic [13:0] B_ERR  = 14'h0001;

    typedef struct packed {
        logic [13:0] ctl;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
        logic [15:0] idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  opcode = '0;
    logic        z = 1'b0;
    logic        mem_ready = 1'b0;
    logic        stack_full = 1'b0;
    logic        stack_empty = 1'b0;

    logic        ir_we, pc_we, s_inc, s_ret, s_inm, we3, wez, push, pop, halted, err;
    logic [2:0]  op_alu;
    logic [15:0] instr_cnt;

    logic        u2_ir_we, u2_pc_we, u2_s_inc, u2_s_ret, u2_s_inm, u2_we3, u2_wez;
    logic        u2_push, u2_pop, u2_halted, u2_err;
    logic [2:0]  u2_op_alu;
    logic [1:0]  u2_cnt;

    exp_t        q[$];
    logic [15:0] exp_cnt = '0;
    int          nvec = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    uc_mc #(.OPW(6), .ALUW(3), .CNTW(16)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .z(z), .mem_ready(mem_ready),
        .stack_full(stack_full), .stack_empty(stack_empty),
        .ir_we(ir_we), .pc_we(pc_we), .s_inc(s_inc), .s_ret(s_ret), .s_inm(s_inm),
        .we3(we3), .wez(wez), .op_alu(op_alu), .push(push), .pop(pop),
        .halted(halted), .err(err), .instr_cnt(instr_cnt)
    );

    uc_mc #(.OPW(6), .ALUW(3), .CNTW(2)) dut_c2 (
        .clk(clk), .reset(reset), .opcode(opcode), .z(z), .mem_ready(mem_ready),
        .stack_full(stack_full), .stack_empty(stack_empty),
        .ir_we(u2_ir_we), .pc_we(u2_pc_we), .s_inc(u2_s_inc), .s_ret(u2_s_ret), .s_inm(u2_s_inm),
        .we3(u2_we3), .wez(u2_wez), .op_alu(u2_op_alu), .push(u2_push), .pop(u2_pop),
        .halted(u2_halted), .err(u2_err), .instr_cnt(u2_cnt)
    );

    // Drive one cycle of inputs and queue the outputs expected in that same cycle.
    task automatic cyc(input logic rst, input logic rdy, input logic [5:0] op, input logic zz,
                       input logic sf, input logic se, input logic [13:0] ectl, input logic inc);
        exp_t e;
        @(posedge clk);
        #1;
        reset       = rst;
        mem_ready   = rdy;
        opcode      = op;
        z           = zz;
        stack_full  = sf;
        stack_empty = se;
        if (rst) exp_cnt = '0;
        e.ctl  = ectl;
        e.cnt  = exp_cnt;
        e.cnt2 = exp_cnt[1:0];
        e.idx  = nvec[15:0];
        nvec++;
        q.push_back(e);
        if (inc) exp_cnt = exp_cnt + 16'd1;
    endtask

    // One full FETCH/DECODE/EXEC pass with mem_ready high.
    task automatic instr(input logic [5:0] op, input logic zz, input logic sf, input logic se,
                         input logic [13:0] ectl, input logic inc);
        cyc(1'b0, 1'b1, op, zz, sf, se, B_IRWE, 1'b0);
        cyc(1'b0, 1'b1, op, zz, sf, se, 14'h0,  1'b0);
        cyc(1'b0, 1'b1, op, zz, sf, se, ectl,   inc);
    endtask

    // Monitor: compare every queued expectation against both instances.
    initial begin : monitor
        exp_t        me;
        logic [13:0] act;
        logic [13:0] act2;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                me   = q.pop_front();
                act  = {ir_we, pc_we, s_inc, s_ret, s_inm, we3, wez, op_alu, push, pop, halted, err};
                act2 = {u2_ir_we, u2_pc_we, u2_s_inc, u2_s_ret, u2_s_inm, u2_we3, u2_wez,
                        u2_op_alu, u2_push, u2_pop, u2_halted, u2_err};
                total++;
                if (act !== me.ctl || act2 !== me.ctl) begin
                    bad++;
                    $display("FAIL ctl vec %0d: got %b / %b, want %b", me.idx, act, act2, me.ctl);
                end
                total++;
                if (instr_cnt !== me.cnt || u2_cnt !== me.cnt2) begin
                    bad++;
                    $display("FAIL cnt vec %0d: got %0d / %0d, want %0d / %0d",
                             me.idx, instr_cnt, u2_cnt, me.cnt, me.cnt2);
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        // Reset state, with inputs that would otherwise advance the FSM.
        cyc(1'b1, 1'b1, 6'b100101, 1'b0, 1'b0, 1'b0, 14'h0, 1'b0);
        cyc(1'b1, 1'b1, 6'b100101, 1'b0, 1'b0, 1'b0, 14'h0, 1'b0);

        // ALU op 101; five retiring instructions walk the 2-bit counter 1,2,3,0,1.
        instr(6'b100101, 1'b0, 1'b0, 1'b0, B_PCWE | B_SINC | B_WE3 | B_WEZ | B_A101, 1'b1);
        // Four-cycle fetch stall, then immediate load.
        repeat (4) cyc(1'b0, 1'b0, 6'b000011, 1'b0, 1'b0, 1'b0, 14'h0, 1'b0);
        instr(6'b000011, 1'b0, 1'b0, 1'b0, B_PCWE | B_SINC | B_SINM | B_WE3, 1'b1);
        // JZ taken (z=1) and not taken (z=0).
        instr(6'b001001, 1'b1, 1'b0, 1'b0, B_PCWE, 1'b1);
        instr(6'b001001, 1'b0, 1'b0, 1'b0, B_PCWE | B_SINC, 1'b1);
        // ALU op 111 completes the fifth instruction.
        instr(6'b111111, 1'b0, 1'b0, 1'b0, B_PCWE | B_SINC | B_WE3 | B_WEZ | B_A111, 1'b1);
        // JNZ both ways, plain J, flow NOP, unassigned-class NOP.
        instr(6'b001010, 1'b1, 1'b0, 1'b0, B_PCWE | B_SINC, 1'b1);
        instr(6'b001010, 1'b0, 1'b0, 1'b0, B_PCWE, 1'b1);
        instr(6'b001000, 1'b0, 1'b0, 1'b0, B_PCWE, 1'b1);
        instr(6'b001101, 1'b0, 1'b0, 1'b0, B_PCWE | B_SINC, 1'b1);
        instr(6'b010000, 1'b0, 1'b0, 1'b0, B_PCWE | B_SINC, 1'b1);
        // CALL with an irrelevant empty flag, RET with an irrelevant full flag.
        instr(6'b001011, 1'b0, 1'b0, 1'b1, B_PCWE | B_PUSH, 1'b1);
        instr(6'b001100, 1'b0, 1'b1, 1'b0, B_PCWE | B_POP | B_SRET, 1'b1);

        // Reset during the would-be EXEC cycle abandons the instruction.
        cyc(1'b0, 1'b1, 6'b100101, 1'b0, 1'b0, 1'b0, B_IRWE, 1'b0);
        cyc(1'b0, 1'b1, 6'b100101, 1'b0, 1'b0, 1'b0, 14'h0,  1'b0);
        cyc(1'b1, 1'b1, 6'b100101, 1'b0, 1'b0, 1'b0, 14'h0,  1'b0);
        instr(6'b000001, 1'b0, 1'b0, 1'b0, B_PCWE | B_SINC | B_SINM | B_WE3, 1'b1);

        // RET on an empty stack: no enables in EXEC, then sticky ERR.
        instr(6'b001100, 1'b0, 1'b0, 1'b1, 14'h0, 1'b0);
        repeat (3) cyc(1'b0, 1'b1, 6'b100101, 1'b0, 1'b0, 1'b0, B_HALT | B_ERR, 1'b0);
        cyc(1'b1, 1'b1, 6'b100101, 1'b0, 1'b0, 1'b0, 14'h0, 1'b0);

        // CALL on a full stack also faults.
        instr(6'b001011, 1'b0, 1'b1, 1'b0, 14'h0, 1'b0);
        cyc(1'b0, 1'b1, 6'b001011, 1'b0, 1'b0, 1'b0, B_HALT | B_ERR, 1'b0);
        cyc(1'b1, 1'b1, 6'b001011, 1'b0, 1'b0, 1'b0, 14'h0, 1'b0);

        // HALT after one retired instruction: halted from the next cycle, counter frozen.
        instr(6'b100101, 1'b0, 1'b0, 1'b0, B_PCWE | B_SINC | B_WE3 | B_WEZ | B_A101, 1'b1);
        instr(6'b011000, 1'b0, 1'b0, 1'b0, 14'h0, 1'b0);
        repeat (3) cyc(1'b0, 1'b1, 6'b100101, 1'b1, 1'b0, 1'b0, B_HALT, 1'b0);
        cyc(1'b1, 1'b1, 6'b100101, 1'b0, 1'b0, 1'b0, 14'h0, 1'b0);
        instr(6'b001000, 1'b0, 1'b0, 1'b0, B_PCWE, 1'b1);
        cyc(1'b0, 1'b0, 6'b001000, 1'b0, 1'b0, 1'b0, 14'h0, 1'b0);

        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
